aggregator_frame_accumulator: RTL and testbench

//  Downstream consumer of the Aggregator's widened sum stream (DATA_OUT/valid/ready).
//  - Accepts one DATA_WIDTH+1 bit sample per handshake.
//  - Accumulates FRAME_LEN samples into a frame sum and tracks the frame peak.
//  - Presents sum, peak and frame index on a held valid/ready output to the next stage.

---
 rtl/aggregator_frame_accumulator.sv | 154 +++++++++++++++
 tb/tb_aggregator_frame_accumulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aggregator_frame_accumulator.sv
// Frame accumulator behind the Aggregator: sums FRAME_LEN widened samples, tracks the peak,
// and presents sum/peak/frame index on a held valid/ready output.
module aggregator_frame_accumulator #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAME_LEN  = 16,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [DATA_WIDTH:0]                   DATA_IN,
    input  logic                                  valid_in,
    output logic                                  ready,
    output logic [DATA_WIDTH+$clog2(FRAME_LEN):0] SUM_OUT,
    output logic [DATA_WIDTH:0]                   PEAK_OUT,
    output logic [FCNT_WIDTH-1:0]                 FRAME_IDX,
    output logic                                  valid_out,
    input  logic                                  ready_in
);

    localparam int SMP_WIDTH = DATA_WIDTH + 1;
    localparam int ACC_WIDTH = DATA_WIDTH + 1 + $clog2(FRAME_LEN);
    localparam int CNT_WIDTH = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 r_state,     w_state_next;
    logic                   r_ready,     w_ready_next;
    logic                   r_valid_out, w_valid_out_next;
    logic [ACC_WIDTH-1:0]   r_acc,       w_acc_next;
    logic [SMP_WIDTH-1:0]   r_peak,      w_peak_next;
    logic [CNT_WIDTH-1:0]   r_cnt,       w_cnt_next;
    logic [FCNT_WIDTH-1:0]  r_fcnt,      w_fcnt_next;
    logic [ACC_WIDTH-1:0]   r_sum_out,   w_sum_out_next;
    logic [SMP_WIDTH-1:0]   r_peak_out,  w_peak_out_next;
    logic [FCNT_WIDTH-1:0]  r_frame_idx, w_frame_idx_next;

    logic                   w_accept;
    logic                   w_present_hs;
    logic                   w_last_sample;
    logic [ACC_WIDTH-1:0]   w_acc_sum;
    logic [SMP_WIDTH-1:0]   w_peak_max;

    assign w_accept      = valid_in && r_ready;
    assign w_present_hs  = r_valid_out && ready_in;
    assign w_last_sample = (r_cnt == CNT_WIDTH'(FRAME_LEN - 1));
    assign w_acc_sum     = r_acc + {{(ACC_WIDTH-SMP_WIDTH){1'b0}}, DATA_IN};
    assign w_peak_max    = (DATA_IN > r_peak) ? DATA_IN : r_peak;

    always_comb begin
        w_state_next     = r_state;
        w_ready_next     = r_ready;
        w_valid_out_next = r_valid_out;
        w_acc_next       = r_acc;
        w_peak_next      = r_peak;
        w_cnt_next       = r_cnt;
        w_fcnt_next      = r_fcnt;
        w_sum_out_next   = r_sum_out;
        w_peak_out_next  = r_peak_out;
        w_frame_idx_next = r_frame_idx;

        case (r_state)
            IDLE: begin
                w_ready_next     = 1'b0;
                w_valid_out_next = 1'b0;
                if (start) begin
                    w_state_next = ACCUM;
                    w_ready_next = 1'b1;
                    w_acc_next   = '0;
                    w_peak_next  = '0;
                    w_cnt_next   = '0;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (w_last_sample) begin
                        // Final sample folds straight into the presented result.
                        w_sum_out_next   = w_acc_sum;
                        w_peak_out_next  = w_peak_max;
                        w_frame_idx_next = r_fcnt;
                        w_valid_out_next = 1'b1;
                        w_ready_next     = 1'b0;
                        w_state_next     = HOLD;
                        w_acc_next       = '0;
                        w_peak_next      = '0;
                        w_cnt_next       = '0;
                    end else begin
                        w_acc_next  = w_acc_sum;
                        w_peak_next = w_peak_max;
                        w_cnt_next  = r_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            HOLD: begin
                w_ready_next = 1'b0;
                if (w_present_hs) begin
                    w_valid_out_next = 1'b0;
                    w_fcnt_next      = r_fcnt + FCNT_WIDTH'(1);
                    w_acc_next       = '0;
                    w_peak_next      = '0;
                    w_cnt_next       = '0;
                    if (start) begin
                        w_state_next = ACCUM;
                        w_ready_next = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_ready_next     = 1'b0;
                w_valid_out_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_valid_out <= 1'b0;
            r_acc       <= '0;
            r_peak      <= '0;
            r_cnt       <= '0;
            r_fcnt      <= '0;
            r_sum_out   <= '0;
            r_peak_out  <= '0;
            r_frame_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ready     <= w_ready_next;
            r_valid_out <= w_valid_out_next;
            r_acc       <= w_acc_next;
            r_peak      <= w_peak_next;
            r_cnt       <= w_cnt_next;
            r_fcnt      <= w_fcnt_next;
            r_sum_out   <= w_sum_out_next;
            r_peak_out  <= w_peak_out_next;
            r_frame_idx <= w_frame_idx_next;
        end
    end

    assign ready     = r_ready;
    assign valid_out = r_valid_out;
    assign SUM_OUT   = r_sum_out;
    assign PEAK_OUT  = r_peak_out;
    assign FRAME_IDX = r_frame_idx;

endmodule

// File: tb/tb_aggregator_frame_accumulator.sv
// Directed bench for aggregator_frame_accumulator: FRAME_LEN=4 main instance, a 2-bit
// frame-counter twin on the same stimulus, and a FRAME_LEN=16 instance for the wide-sum case.
module tb_aggregator_frame_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, valid_in, ready_in;
    logic [12:0] din;
    logic        ready, valid_out;
    logic [14:0] sum_out;
    logic [12:0] peak_out;
    logic [15:0] frame_idx;

    logic        ready_w2, valid_w2;
    logic [14:0] sum_w2;
    logic [12:0] peak_w2;
    logic [1:0]  idx_w2;

    logic        start16, valid16, ready_in16;
    logic [12:0] din16;
    logic        ready16, valid16_out;
    logic [16:0] sum16;
    logic [12:0] peak16;
    logic [15:0] idx16;

    int n_cmp = 0;
    int n_err = 0;

    aggregator_frame_accumulator #(.DATA_WIDTH(12), .FRAME_LEN(4), .FCNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .DATA_IN(din), .valid_in(valid_in),
        .ready(ready), .SUM_OUT(sum_out), .PEAK_OUT(peak_out), .FRAME_IDX(frame_idx),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    aggregator_frame_accumulator #(.DATA_WIDTH(12), .FRAME_LEN(4), .FCNT_WIDTH(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .start(start), .DATA_IN(din), .valid_in(valid_in),
        .ready(ready_w2), .SUM_OUT(sum_w2), .PEAK_OUT(peak_w2), .FRAME_IDX(idx_w2),
        .valid_out(valid_w2), .ready_in(ready_in)
    );

    aggregator_frame_accumulator #(.DATA_WIDTH(12), .FRAME_LEN(16), .FCNT_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .DATA_IN(din16), .valid_in(valid16),
        .ready(ready16), .SUM_OUT(sum16), .PEAK_OUT(peak16), .FRAME_IDX(idx16),
        .valid_out(valid16_out), .ready_in(ready_in16)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        valid_in = 1'b1;
        din = d;
        while (!acc && n < 50) begin
            acc = ready;
            tick();
            n++;
        end
        valid_in = 1'b0;
        din = 13'h1ABC;
        if (!acc) check_value("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send16(input logic [12:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        valid16 = 1'b1;
        din16 = d;
        while (!acc && n < 50) begin
            acc = ready16;
            tick();
            n++;
        end
        valid16 = 1'b0;
        din16 = 13'h0555;
        if (!acc) check_value("send16_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input logic [12:0] a, input logic [12:0] b, input logic [12:0] c,
                             input logic [12:0] e, input int gap, input int exp_sum,
                             input int exp_peak, input int exp_idx, input bit keep_start,
                             input int hold);
        ready_in = 1'b0;
        send(a); repeat (gap) tick();
        send(b); repeat (gap) tick();
        send(c); repeat (gap) tick();
        send(e);
        check_value("valid_out", 32'(valid_out), 32'd1);
        check_value("ready_in_hold", 32'(ready), 32'd0);
        check_value("sum", 32'(sum_out), 32'(exp_sum));
        check_value("peak", 32'(peak_out), 32'(exp_peak));
        check_value("frame_idx", 32'(frame_idx), 32'(exp_idx));
        check_value("w2_sum", 32'(sum_w2), 32'(exp_sum));
        check_value("w2_idx", 32'(idx_w2), 32'(exp_idx % 4));
        $display("frame idx=%0d idx2=%0d sum=%0d peak=%0d", frame_idx, idx_w2, sum_out, peak_out);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_value("stall_valid", 32'(valid_out), 32'd1);
            check_value("stall_ready", 32'(ready), 32'd0);
            check_value("stall_sum", 32'(sum_out), 32'(exp_sum));
            check_value("stall_peak", 32'(peak_out), 32'(exp_peak));
        end
        start = keep_start;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check_value("post_hs_valid", 32'(valid_out), 32'd0);
        check_value("post_hs_ready", 32'(ready), 32'(keep_start));
        check_value("post_hs_sum", 32'(sum_out), 32'(exp_sum));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; valid_in = 1'b0; ready_in = 1'b0; din = '0;
        start16 = 1'b0; valid16 = 1'b0; ready_in16 = 1'b0; din16 = '0;
        tick(); tick();
        check_value("rst_ready", 32'(ready), 32'd0);
        check_value("rst_valid", 32'(valid_out), 32'd0);
        check_value("rst_sum", 32'(sum_out), 32'd0);
        check_value("rst_peak", 32'(peak_out), 32'd0);
        check_value("rst_idx", 32'(frame_idx), 32'd0);
        reset = 1'b1;
        tick();
        check_value("idle_ready", 32'(ready), 32'd0);
        start = 1'b1;
        tick();
        check_value("ready_after_start", 32'(ready), 32'd1);

        // Back-to-back frame, then gapped frame with a 5-cycle downstream stall
        run_frame(13'd1, 13'd2, 13'd3, 13'd4, 0, 10, 4, 0, 1'b1, 0);
        run_frame(13'd7, 13'd0, 13'd9, 13'd2, 3, 18, 9, 1, 1'b1, 5);

        // Reset part-way through a frame
        send(13'd1);
        send(13'd1);
        reset = 1'b0;
        tick();
        check_value("midrst_ready", 32'(ready), 32'd0);
        check_value("midrst_valid", 32'(valid_out), 32'd0);
        check_value("midrst_sum", 32'(sum_out), 32'd0);
        check_value("midrst_idx", 32'(frame_idx), 32'd0);
        check_value("midrst_w2_idx", 32'(idx_w2), 32'd0);
        reset = 1'b1;
        run_frame(13'd5, 13'd5, 13'd5, 13'd5, 0, 20, 5, 0, 1'b1, 0);

        // Three frames from a clean reset, start dropped before the last hand-off
        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_frame(13'd10, 13'd20, 13'd30, 13'd40, 0, 100, 40, 0, 1'b1, 0);
        run_frame(13'h1FFF, 13'd0, 13'd1, 13'd2, 1, 8194, 8191, 1, 1'b1, 0);
        run_frame(13'd3, 13'd3, 13'd3, 13'd3, 0, 12, 3, 2, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("idle_after_drop_ready", 32'(ready), 32'd0);
        end
        check_value("idle_after_drop_valid", 32'(valid_out), 32'd0);

        // Continue to frames 3 and 4: the 2-bit counter wraps to 0
        start = 1'b1;
        run_frame(13'd100, 13'd50, 13'd200, 13'd25, 0, 375, 200, 3, 1'b1, 0);
        run_frame(13'd4, 13'd1, 13'd0, 13'd1, 0, 6, 4, 4, 1'b0, 0);

        // Sixteen full-scale samples on the FRAME_LEN=16 instance
        start16 = 1'b1;
        for (int i = 0; i < 16; i++) send16(13'h1FFF);
        check_value("f16_valid", 32'(valid16_out), 32'd1);
        check_value("f16_sum", 32'(sum16), 32'h1FFF0);
        check_value("f16_peak", 32'(peak16), 32'h1FFF);
        check_value("f16_idx", 32'(idx16), 32'd0);
        $display("frame16 idx=%0d sum=0x%0h peak=0x%0h", idx16, sum16, peak16);
        start16 = 1'b0;
        ready_in16 = 1'b1;
        tick();
        check_value("f16_post_hs_valid", 32'(valid16_out), 32'd0);
        check_value("f16_post_hs_ready", 32'(ready16), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
